rls_frame_loader: RTL and testbench

Upstream feeder for `RLSBlock`. It accepts one problem frame as a serial stream of `WIDTH`-bit words over a valid/ready handshake and assembles the wide `x0`, `b_SIZE`, `a_SIZE` and `k_SIZE` buses. It sequences `RLSBlock`'s active-high load/hold `reset` input and watches its `ready` output. The next frame may stream in while the current solve runs; the solver keeps its own copies of the buses.

---
 rtl/rls_pkg.sv | 28 ++
 rtl/rls_word_counter.sv | 80 ++++++++
 rtl/rls_frame_loader.sv | 172 +++++++++++++++++
 tb/tb_rls_frame_loader.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rls_pkg.sv
// Shared definitions for the RLS frame loader: frame geometry, write-phase
// encoding and loader FSM states.
package rls_pkg;

    // Words in one frame: x0 vector, then ITER rows of {b, a[SIZE], k[SIZE]}.
    function automatic int unsigned frame_len(input int unsigned size, input int unsigned iter);
        return size + iter * (1 + 2 * size);
    endfunction

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned ITER_DEF  = 32;
    localparam int unsigned SIZE_DEF  = 16;
    localparam int unsigned FRAME_LEN = frame_len(SIZE_DEF, ITER_DEF);

    typedef enum logic [1:0] {
        PH_X0,
        PH_B,
        PH_A,
        PH_K
    } phase_e;

    typedef enum logic [1:0] {
        LOAD,
        PEND,
        LAUNCH
    } state_e;

endpackage

// File: rtl/rls_word_counter.sv
// Phase/row/column write counter for one RLS frame. Advances one word per
// inc, returns to X0/row 0/column 0 after the last k word of the last row.
module rls_word_counter
    import rls_pkg::*;
#(
    parameter int unsigned SIZE  = 16,
    parameter int unsigned ITER  = 32,
    parameter int unsigned COL_W = (SIZE > 1) ? $clog2(SIZE) : 1,
    parameter int unsigned ROW_W = (ITER > 1) ? $clog2(ITER) : 1,
    parameter int unsigned IDX_W = $clog2(frame_len(SIZE, ITER))
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output phase_e           phase,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic [IDX_W-1:0] word_idx,
    output logic             last_word
);

    logic col_end;

    // End-of-vector and end-of-frame detection from the current position.
    always_comb begin
        col_end   = (col == COL_W'(SIZE - 1));
        last_word = (phase == PH_K) && col_end && (row == ROW_W'(ITER - 1));
    end

    // Advance through x0, then per row b, a[0..SIZE-1], k[0..SIZE-1].
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            phase    <= PH_X0;
            row      <= '0;
            col      <= '0;
            word_idx <= '0;
        end else if (inc) begin
            if (last_word) begin
                phase    <= PH_X0;
                row      <= '0;
                col      <= '0;
                word_idx <= '0;
            end else begin
                word_idx <= word_idx + IDX_W'(1);
                unique case (phase)
                    PH_X0: begin
                        if (col_end) begin
                            phase <= PH_B;
                            col   <= '0;
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                    PH_B: begin
                        phase <= PH_A;
                    end
                    PH_A: begin
                        if (col_end) begin
                            phase <= PH_K;
                            col   <= '0;
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                    PH_K: begin
                        if (col_end) begin
                            phase <= PH_B;
                            col   <= '0;
                            row   <= row + ROW_W'(1);
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/rls_frame_loader.sv
// Serial frame loader feeding RLSBlock: assembles x0/b/a/k buses from a
// valid/ready word stream and sequences the solver's load/run reset.
// Optional end-of-frame checking via in_last: define RLS_LOADER_LAST_EN.
module rls_frame_loader
    import rls_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32,
    parameter int unsigned SIZE  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
`ifdef RLS_LOADER_LAST_EN
    input  logic                        in_last,
`endif
    output logic [WIDTH*SIZE-1:0]       x0,
    output logic [WIDTH*ITER-1:0]       b_SIZE,
    output logic [WIDTH*SIZE*ITER-1:0]  a_SIZE,
    output logic [WIDTH*SIZE*ITER-1:0]  k_SIZE,
    output logic                        rls_reset,
    input  logic                        rls_ready,
    output logic                        busy,
    output logic [15:0]                 frame_count,
    output logic [7:0]                  err_count
);

    localparam int unsigned FLEN  = frame_len(SIZE, ITER);
    localparam int unsigned COL_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned ROW_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int unsigned IDX_W = $clog2(FLEN);

    state_e           state, state_next;
    phase_e           phase;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [IDX_W-1:0] word_idx;
    logic             last_word;
    logic             accept;
    logic             frame_good;
    logic             ctr_clear;
    logic             launch;
    logic             frame_full;

    rls_word_counter #(
        .SIZE  (SIZE),
        .ITER  (ITER),
        .COL_W (COL_W),
        .ROW_W (ROW_W),
        .IDX_W (IDX_W)
    ) u_counter (
        .clk       (clk),
        .reset     (reset),
        .clear     (ctr_clear),
        .inc       (accept),
        .phase     (phase),
        .row       (row),
        .col       (col),
        .word_idx  (word_idx),
        .last_word (last_word)
    );

    assign accept = in_valid && in_ready;

`ifdef RLS_LOADER_LAST_EN
    logic frame_bad;

    // A frame is good only if in_last marks exactly its final word; an early
    // in_last restarts the counters at word 0.
    always_comb begin
        frame_good = accept && last_word && in_last;
        frame_bad  = accept && (in_last != last_word);
        ctr_clear  = accept && in_last && !last_word;
    end

    // Saturating malformed-frame counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (frame_bad && (err_count != '1)) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    // Framing by word count only.
    always_comb begin
        frame_good = accept && last_word;
        ctr_clear  = 1'b0;
    end

    assign err_count = '0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: load, wait for the solver to go idle, then one launch cycle.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        unique case (state)
            LOAD: begin
                if (frame_good) begin
                    state_next = PEND;
                end
            end
            PEND: begin
                if (!busy && frame_full) begin
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                launch     = 1'b1;
                state_next = LOAD;
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // Handshake and solver sequencing; rls_reset is low only while a solve runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready    <= 1'b0;
            rls_reset   <= 1'b1;
            busy        <= 1'b0;
            frame_full  <= 1'b0;
            frame_count <= '0;
        end else begin
            in_ready <= (state_next == LOAD);
            if (frame_good) begin
                frame_full <= 1'b1;
            end
            if (launch) begin
                rls_reset   <= 1'b0;
                busy        <= 1'b1;
                frame_full  <= 1'b0;
                frame_count <= frame_count + 16'd1;
            end else if (busy && rls_ready) begin
                busy      <= 1'b0;
                rls_reset <= 1'b1;
            end
        end
    end

    // Bus assembly; words land unmodified at the slot selected by the counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            x0     <= '0;
            b_SIZE <= '0;
            a_SIZE <= '0;
            k_SIZE <= '0;
        end else if (accept) begin
            unique case (phase)
                PH_X0: x0[WIDTH*32'(word_idx) +: WIDTH]                    <= in_data;
                PH_B:  b_SIZE[WIDTH*32'(row) +: WIDTH]                     <= in_data;
                PH_A:  a_SIZE[WIDTH*(SIZE*32'(row) + 32'(col)) +: WIDTH]   <= in_data;
                PH_K:  k_SIZE[WIDTH*(SIZE*32'(row) + 32'(col)) +: WIDTH]   <= in_data;
            endcase
        end
    end

endmodule

// File: tb/tb_rls_frame_loader.sv
// Bench for rls_frame_loader: directed frames against a cycle-level
// behavioural model of the loader, plus fixed hand-computed expectations.
module tb_rls_frame_loader;

    localparam int W    = 32;
    localparam int S    = 16;
    localparam int I    = 32;
    localparam int FL   = S + I * (1 + 2 * S);
    localparam int BUSW = W * S * I;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [W-1:0]       in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
`ifdef RLS_LOADER_LAST_EN
    logic               in_last = 1'b0;
`endif
    logic [W*S-1:0]     x0;
    logic [W*I-1:0]     b_SIZE;
    logic [BUSW-1:0]    a_SIZE;
    logic [BUSW-1:0]    k_SIZE;
    logic               rls_reset;
    logic               rls_ready = 1'b0;
    logic               busy;
    logic [15:0]        frame_count;
    logic [7:0]         err_count;

    int checks = 0;
    int errors = 0;

    int solve_len = 600;
    int run_cnt   = 0;

    rls_frame_loader #(
        .WIDTH (W),
        .ITER  (I),
        .SIZE  (S)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
`ifdef RLS_LOADER_LAST_EN
        .in_last     (in_last),
`endif
        .x0          (x0),
        .b_SIZE      (b_SIZE),
        .a_SIZE      (a_SIZE),
        .k_SIZE      (k_SIZE),
        .rls_reset   (rls_reset),
        .rls_ready   (rls_ready),
        .busy        (busy),
        .frame_count (frame_count),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_bus(input string name, input logic [BUSW-1:0] act,
                           input logic [BUSW-1:0] exp, input int nwords);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int w = 0; w < nwords; w++) begin
                if (act[W*w +: W] !== exp[W*w +: W]) begin
                    $display("FAIL %s word %0d actual=%0h required=%0h at %0t",
                             name, w, act[W*w +: W], exp[W*w +: W], $time);
                    break;
                end
            end
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W*S-1:0]  m_x0;
    logic [W*I-1:0]  m_b;
    logic [BUSW-1:0] m_a;
    logic [BUSW-1:0] m_k;
    int   m_pos;
    int   m_fc;
    int   m_err;
    bit   m_busy, m_in_ready, pending, launching, model_on = 0;

    // Place a frame word by its position in the frame.
    task automatic model_store(input int p, input logic [W-1:0] d);
        int r, i, o;
        if (p < S) begin
            m_x0[W*p +: W] = d;
        end else begin
            r = p - S;
            i = r / (2 * S + 1);
            o = r % (2 * S + 1);
            if (o == 0)      m_b[W*i +: W] = d;
            else if (o <= S) m_a[W*(S*i + o - 1) +: W] = d;
            else             m_k[W*(S*i + o - 1 - S) +: W] = d;
        end
    endtask

    always @(negedge clk) begin
        bit acc, lst, n_busy;
        if (model_on) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, m_in_ready});
            chk("rls_reset", {31'd0, rls_reset}, {31'd0, !m_busy});
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("frame_count", {16'd0, frame_count}, m_fc);
            chk("err_count", {24'd0, err_count}, m_err);
            chk_bus("x0", BUSW'(x0), BUSW'(m_x0), S);
            chk_bus("b_SIZE", BUSW'(b_SIZE), BUSW'(m_b), I);
            chk_bus("a_SIZE", a_SIZE, m_a, S * I);
            chk_bus("k_SIZE", k_SIZE, m_k, S * I);
        end
        if (reset) begin
            model_on   = 1;
            m_x0       = '0;
            m_b        = '0;
            m_a        = '0;
            m_k        = '0;
            m_pos      = 0;
            m_fc       = 0;
            m_err      = 0;
            m_busy     = 0;
            m_in_ready = 0;
            pending    = 0;
            launching  = 0;
        end else if (model_on) begin
            acc    = in_valid && m_in_ready;
            n_busy = m_busy && !rls_ready;
            if (launching) begin
                n_busy    = 1;
                m_fc      = (m_fc + 1) % 65536;
                launching = 0;
                pending   = 0;
            end else if (pending && !m_busy) begin
                launching = 1;
            end
            if (acc) begin
                model_store(m_pos, in_data);
`ifdef RLS_LOADER_LAST_EN
                lst = in_last;
`else
                lst = (m_pos == FL - 1);
`endif
                if (m_pos == FL - 1) begin
                    if (lst) pending = 1;
                    else if (m_err < 255) m_err++;
                    m_pos = 0;
                end else if (lst) begin
                    if (m_err < 255) m_err++;
                    m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
            m_busy     = n_busy;
            m_in_ready = !(pending || launching);
        end
    end

    // ---------------- stimulus ----------------
    // One clock; the solver stand-in raises ready solve_len cycles into a run.
    task automatic step();
        @(posedge clk);
        #1;
        if (rls_reset) begin
            run_cnt   = 0;
            rls_ready = 1'b0;
        end else begin
            run_cnt++;
            rls_ready = (run_cnt >= solve_len);
        end
    endtask

    task automatic stream(input int base, input int nwords, input bit bursty,
                          input int last_at, output int k);
        int  idx;
        bit  acc;
        idx = 0;
        k   = 0;
        while (idx < nwords && k < 20000) begin
            in_valid = !(bursty && (k % 3 == 0));
            in_data  = W'(base + idx);
`ifdef RLS_LOADER_LAST_EN
            in_last  = (idx == last_at);
`endif
            acc = in_valid && in_ready;
            step();
            k++;
            if (acc) idx++;
        end
        in_valid = 1'b0;
`ifdef RLS_LOADER_LAST_EN
        in_last  = 1'b0;
`endif
        chk("stream_words", idx, nwords);
    endtask

    task automatic wait_busy(input logic val, input string name);
        int n;
        n = 0;
        while (busy !== val && n < 5000) begin
            step();
            n++;
        end
        chk(name, {31'd0, busy}, {31'd0, val});
    endtask

    initial begin
        int k, n;

        // Reset values and in_ready release timing.
        reset = 1'b1;
        repeat (3) step();
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_rls_reset", {31'd0, rls_reset}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_frame_count", {16'd0, frame_count}, 0);
        chk("rst_err_count", {24'd0, err_count}, 0);
        reset = 1'b0;
        step();
        chk("in_ready_rise", {31'd0, in_ready}, 1);

        // Single back-to-back frame, data = word index.
        stream(0, FL, 0, FL - 1, k);
        n = 1;
        while (rls_reset && n < 50) begin
            step();
            n++;
        end
        chk("launch_edges", n, 3);
        chk("frame_count_1", {16'd0, frame_count}, 1);
        chk("a_2_3", a_SIZE[W*(S*2 + 3) +: W], 86);
        chk("k_0_0", k_SIZE[0 +: W], 33);
        chk("x0_5", x0[W*5 +: W], 5);
        chk("b_31", b_SIZE[W*31 +: W], 1039);
        wait_busy(1'b0, "solve1_done");

        // Bursty valid: low every third cycle.
        stream(0, FL, 1, FL - 1, k);
        chk("bursty_cycles", k, 1608);
        wait_busy(1'b1, "launch2");
        chk("frame_count_2", {16'd0, frame_count}, 2);
        chk("a_2_3_bursty", a_SIZE[W*(S*2 + 3) +: W], 86);
        wait_busy(1'b0, "solve2_done");

        // Overlap: next frame loads while a long solve runs, then waits.
        solve_len = 1500;
        stream(1000, FL, 0, FL - 1, k);
        wait_busy(1'b1, "launch3");
        stream(2000, FL, 0, FL - 1, k);
        chk("pend_in_ready", {31'd0, in_ready}, 0);
        chk("pend_busy", {31'd0, busy}, 1);
        chk("pend_frame_count", {16'd0, frame_count}, 3);
        wait_busy(1'b0, "solve3_done");
        wait_busy(1'b1, "launch4");
        chk("frame_count_4", {16'd0, frame_count}, 4);
        chk("a_2_3_f4", a_SIZE[W*(S*2 + 3) +: W], 2086);
        solve_len = 600;

        // Reset mid-frame during a solve.
        stream(3000, 500, 0, FL - 1, k);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("mid_rst_count", {16'd0, frame_count}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_x0", x0[0 +: W], 0);
        stream(5000, FL, 0, FL - 1, k);
        wait_busy(1'b1, "launch_after_rst");
        chk("after_rst_count", {16'd0, frame_count}, 1);
        chk("after_rst_x0_0", x0[0 +: W], 5000);
        chk("after_rst_b_0", b_SIZE[0 +: W], 5016);
        wait_busy(1'b0, "solve5_done");

`ifdef RLS_LOADER_LAST_EN
        // Early in_last on word 100: rejected, then a good frame launches.
        stream(7000, 101, 0, 100, k);
        repeat (3) step();
        chk("early_last_err", {24'd0, err_count}, 1);
        chk("early_last_no_launch", {16'd0, frame_count}, 1);
        chk("early_last_busy", {31'd0, busy}, 0);
        stream(8000, FL, 0, FL - 1, k);
        wait_busy(1'b1, "launch_after_err");
        chk("after_err_count", {16'd0, frame_count}, 2);
        chk("after_err_err", {24'd0, err_count}, 1);
        chk("after_err_x0_0", x0[0 +: W], 8000);
        wait_busy(1'b0, "solve6_done");
`endif

        repeat (4) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

endmodule
